// File: rtl/siu_l2_trk_pkg.sv
// Shared types and defaults for the SIU->L2 request tracker.
// Pure declarations: no latency, no backpressure.
package siu_l2_trk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    GAP  = 2'd2
  } trk_state_e;

  localparam int DEF_NUM_L2T    = 8;
  localparam int DEF_REQ_W      = 32;
  localparam int DEF_HDR_CYCLES = 2;
  localparam int DEF_GAP_CYCLES = 3;
  localparam int DEF_MAX_OUTST  = 16;
  localparam int STAT_W         = 32;

  // One counter walks both the header beats and the gap, so size it for the longer phase.
  function automatic int seq_w(input int hdr_cycles, input int gap_cycles);
    int m;
    m = (hdr_cycles > gap_cycles) ? hdr_cycles : gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/siu_l2_req_tracker_if.sv
// Tap bundle between the SII request/dequeue wires and the tracker; stats ports only
// with SIU_L2_TRK_STATS_EN. No latency, no backpressure (observe-only).
interface siu_l2_req_tracker_if
  import siu_l2_trk_pkg::*;
#(
  parameter int NUM_L2T    = DEF_NUM_L2T,
  parameter int REQ_W      = DEF_REQ_W,
  parameter int HDR_CYCLES = DEF_HDR_CYCLES,
  parameter int MAX_OUTST  = DEF_MAX_OUTST,
  parameter int CNT_W      = $clog2(MAX_OUTST + 1)
);

  logic [NUM_L2T*REQ_W-1:0]            req;
  logic [NUM_L2T-1:0]                  req_vld;
  logic [NUM_L2T-1:0]                  iq_dequeue;
  logic [NUM_L2T-1:0]                  wib_dequeue;
  logic                                err_clr;
  logic [NUM_L2T-1:0]                  hdr_vld;
  logic [NUM_L2T*HDR_CYCLES*REQ_W-1:0] hdr;
  logic [NUM_L2T*CNT_W-1:0]            outst_cnt;
  logic [NUM_L2T-1:0]                  proto_err;
  logic [NUM_L2T-1:0]                  ovf_err;
  logic [NUM_L2T-1:0]                  unf_err;
`ifdef SIU_L2_TRK_STATS_EN
  logic [NUM_L2T*STAT_W-1:0]           stat_req;
  logic [NUM_L2T*STAT_W-1:0]           stat_iqdq;
  logic [NUM_L2T*STAT_W-1:0]           stat_wibdq;
`endif

  modport master (
    output req, req_vld, iq_dequeue, wib_dequeue, err_clr,
`ifdef SIU_L2_TRK_STATS_EN
    input  stat_req, stat_iqdq, stat_wibdq,
`endif
    input  hdr_vld, hdr, outst_cnt, proto_err, ovf_err, unf_err
  );

  modport slave (
    input  req, req_vld, iq_dequeue, wib_dequeue, err_clr,
`ifdef SIU_L2_TRK_STATS_EN
    output stat_req, stat_iqdq, stat_wibdq,
`endif
    output hdr_vld, hdr, outst_cnt, proto_err, ovf_err, unf_err
  );

endinterface

// File: rtl/siu_l2_trk_chan.sv
// One L2T bank: header assembly FSM, outstanding IQ counter, sticky errors, stats with
// SIU_L2_TRK_STATS_EN. req_vld -> hdr_vld is HDR_CYCLES+1 cycles; no backpressure, illegal vld flagged.
module siu_l2_trk_chan
  import siu_l2_trk_pkg::*;
#(
  parameter int REQ_W      = DEF_REQ_W,
  parameter int HDR_CYCLES = DEF_HDR_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MAX_OUTST  = DEF_MAX_OUTST,
  parameter int CNT_W      = $clog2(MAX_OUTST + 1)
) (
  input  logic                        iol2clk,
  input  logic                        rst_l,
  input  logic [REQ_W-1:0]            req,
  input  logic                        req_vld,
  input  logic                        iq_dequeue,
`ifdef SIU_L2_TRK_STATS_EN
  input  logic                        wib_dequeue,
  output logic [STAT_W-1:0]           stat_req,
  output logic [STAT_W-1:0]           stat_iqdq,
  output logic [STAT_W-1:0]           stat_wibdq,
`endif
  input  logic                        err_clr,
  output logic                        hdr_vld,
  output logic [HDR_CYCLES*REQ_W-1:0] hdr,
  output logic [CNT_W-1:0]            outst_cnt,
  output logic                        proto_err,
  output logic                        ovf_err,
  output logic                        unf_err
);

  localparam int HW    = HDR_CYCLES * REQ_W;
  localparam int SEQ_W = seq_w(HDR_CYCLES, GAP_CYCLES);
  localparam logic [SEQ_W-1:0] HDR_LAST = SEQ_W'(HDR_CYCLES - 1);
  localparam logic [SEQ_W-1:0] GAP_LAST = SEQ_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);

  trk_state_e       state, state_nxt;
  logic [SEQ_W-1:0] seq_cnt, seq_cnt_nxt;
  logic [HW-1:0]    shadow, shadow_nxt;
  logic             accept, beat, last_beat, proto_ev;
  logic             ovf_ev, unf_ev;

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= IDLE;
      seq_cnt <= '0;
    end else begin
      state   <= state_nxt;
      seq_cnt <= seq_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt;
    accept      = 1'b0;
    beat        = 1'b0;
    last_beat   = 1'b0;
    proto_ev    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_vld) begin
          accept      = 1'b1;
          state_nxt   = HDR;
          seq_cnt_nxt = '0;
        end
      end
      HDR: begin
        proto_ev = req_vld;
        beat     = 1'b1;
        if (seq_cnt == HDR_LAST) begin
          last_beat   = 1'b1;
          seq_cnt_nxt = '0;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          seq_cnt_nxt = seq_cnt + SEQ_W'(1);
        end
      end
      GAP: begin
        proto_ev = req_vld;
        if (seq_cnt == GAP_LAST) begin
          seq_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          seq_cnt_nxt = seq_cnt + SEQ_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        seq_cnt_nxt = '0;
      end
    endcase
  end

  // Older beats shift toward the MSBs, so the first beat lands on top after HDR_CYCLES shifts.
  assign shadow_nxt = (shadow << REQ_W) | HW'(req);

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      shadow  <= '0;
      hdr     <= '0;
      hdr_vld <= 1'b0;
    end else begin
      hdr_vld <= last_beat;
      if (beat)      shadow <= shadow_nxt;
      if (last_beat) hdr    <= shadow_nxt;
    end
  end

  // Accept and dequeue together cancel, which also suppresses both saturation errors.
  assign ovf_ev = accept && !iq_dequeue && (outst_cnt == CNT_MAX);
  assign unf_ev = iq_dequeue && !accept && (outst_cnt == '0);

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      outst_cnt <= '0;
    end else if (accept && !iq_dequeue && !ovf_ev) begin
      outst_cnt <= outst_cnt + CNT_W'(1);
    end else if (iq_dequeue && !accept && !unf_ev) begin
      outst_cnt <= outst_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      proto_err <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      proto_err <= proto_ev | (proto_err & ~err_clr);
      ovf_err   <= ovf_ev   | (ovf_err   & ~err_clr);
      unf_err   <= unf_ev   | (unf_err   & ~err_clr);
    end
  end

`ifdef SIU_L2_TRK_STATS_EN
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      stat_req   <= '0;
      stat_iqdq  <= '0;
      stat_wibdq <= '0;
    end else begin
      stat_req   <= stat_req   + STAT_W'(accept);
      stat_iqdq  <= stat_iqdq  + STAT_W'(iq_dequeue);
      stat_wibdq <= stat_wibdq + STAT_W'(wib_dequeue);
    end
  end
`endif

endmodule

// File: rtl/siu_l2_req_tracker.sv
// SIU->L2 request tracker: NUM_L2T independent bank trackers; SIU_L2_TRK_STATS_EN adds stats.
// req_vld -> hdr_vld is HDR_CYCLES+1 cycles per bank; no backpressure, observe-only.
module siu_l2_req_tracker
  import siu_l2_trk_pkg::*;
#(
  parameter int NUM_L2T    = DEF_NUM_L2T,
  parameter int REQ_W      = DEF_REQ_W,
  parameter int HDR_CYCLES = DEF_HDR_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MAX_OUTST  = DEF_MAX_OUTST,
  parameter int CNT_W      = $clog2(MAX_OUTST + 1)
) (
  input logic                 iol2clk,
  input logic                 rst_l,
  siu_l2_req_tracker_if.slave bus
);

  localparam int HW = HDR_CYCLES * REQ_W;

`ifndef SIU_L2_TRK_STATS_EN
  logic unused_wib;
  assign unused_wib = ^bus.wib_dequeue;
`endif

  for (genvar i = 0; i < NUM_L2T; i++) begin : g_chan
    siu_l2_trk_chan #(
      .REQ_W      (REQ_W),
      .HDR_CYCLES (HDR_CYCLES),
      .GAP_CYCLES (GAP_CYCLES),
      .MAX_OUTST  (MAX_OUTST),
      .CNT_W      (CNT_W)
    ) u_chan (
      .iol2clk     (iol2clk),
      .rst_l       (rst_l),
      .req         (bus.req[i*REQ_W +: REQ_W]),
      .req_vld     (bus.req_vld[i]),
      .iq_dequeue  (bus.iq_dequeue[i]),
`ifdef SIU_L2_TRK_STATS_EN
      .wib_dequeue (bus.wib_dequeue[i]),
      .stat_req    (bus.stat_req[i*STAT_W +: STAT_W]),
      .stat_iqdq   (bus.stat_iqdq[i*STAT_W +: STAT_W]),
      .stat_wibdq  (bus.stat_wibdq[i*STAT_W +: STAT_W]),
`endif
      .err_clr     (bus.err_clr),
      .hdr_vld     (bus.hdr_vld[i]),
      .hdr         (bus.hdr[i*HW +: HW]),
      .outst_cnt   (bus.outst_cnt[i*CNT_W +: CNT_W]),
      .proto_err   (bus.proto_err[i]),
      .ovf_err     (bus.ovf_err[i]),
      .unf_err     (bus.unf_err[i])
    );
  end

endmodule
